// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: queues host writes and launches one
// UART transmission per byte, waiting for the UART busy handshake to complete.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr_ovf,
  input  logic              uart_busy,
  output logic              uart_transmit,
  output logic [7:0]        uart_tx_byte,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  logic [7:0]        mem [DEPTH];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              transmit_q;
  logic [7:0]        tx_byte_q;
  logic              full_w, empty_w, push, pop;

  // Flags come only from the registered count, never from wr_en.
  assign full_w  = (count_q == FULL_COUNT);
  assign empty_w = (count_q == '0);
  assign push    = wr_en && !full_w;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_w && !uart_busy) begin
          pop     = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (uart_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!uart_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // A dropped write beats a simultaneous clear so no overflow event is lost.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && full_w) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      transmit_q <= (state_d == LAUNCH);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PTR_ONE;
        tx_byte_q <= mem[rd_ptr_q];
      end
    end
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign uart_transmit = transmit_q;
  assign uart_tx_byte  = tx_byte_q;
  assign full          = full_w;
  assign empty         = empty_w;
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign busy          = !empty_w || (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a monitor
// checks every UART strobe, and a small UART model drives uart_busy.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr_ovf = 1'b0;
  logic       uart_busy = 1'b0;
  logic       uart_transmit;
  logic [7:0] uart_tx_byte;
  logic       full, empty, overflow, busy;
  logic [4:0] count;

  int         n_checks = 0;
  int         n_fail = 0;
  int         strobe_cnt = 0;
  logic [7:0] exp_q[$];

  logic       hold_busy = 1'b0;
  logic       gap_chk = 1'b0;
  int         model_cnt = 0;
  bit         fall_pend = 1'b0;
  int         since = 0;
  logic       prev_tx = 1'b0;

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
    .uart_busy(uart_busy), .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    if (accept) exp_q.push_back(d);
  endtask

  task automatic wait_drain(input int max_cycles);
    int i;
    for (i = 0; i < max_cycles && (busy || uart_busy || exp_q.size() != 0); i++) tick();
    if (i == max_cycles) check("drain_timeout", {31'd0, busy}, 0);
  endtask

  // UART model: busy rises with the strobe, stays up 6 cycles; checks restart gap.
  always @(negedge clk) begin
    if (fall_pend) since++;
    if (uart_transmit) begin
      if (fall_pend && gap_chk) check("restart_gap", since, 2);
      fall_pend = 1'b0;
      model_cnt = 6;
    end else if (model_cnt == 1) begin
      model_cnt = 0;
      fall_pend = 1'b1;
      since     = 0;
    end else if (model_cnt != 0) begin
      model_cnt--;
    end
    if (since > 2) fall_pend = 1'b0;
    uart_busy = hold_busy || (model_cnt != 0);
  end

  // Monitor: every strobe must carry the next expected byte.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (uart_transmit) begin
      strobe_cnt++;
      $display("strobe %0d: byte %02h", strobe_cnt, uart_tx_byte);
      check("no_consecutive_strobe", {31'd0, prev_tx}, 0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got byte %02h, required no strobe", uart_tx_byte);
      end else begin
        exp_b = exp_q.pop_front();
        check("tx_byte_order", {24'd0, uart_tx_byte}, {24'd0, exp_b});
      end
    end
    prev_tx = uart_transmit;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    repeat (3) tick();
    check("rst_empty", {31'd0, empty}, 1);
    check("rst_full", {31'd0, full}, 0);
    check("rst_count", {27'd0, count}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_transmit", {31'd0, uart_transmit}, 0);
    check("rst_tx_byte", {24'd0, uart_tx_byte}, 0);
    rst = 1'b0;
    tick();

    // Single byte latency
    wr(8'hA5, 1'b1);
    wr_en = 1'b0;
    check("single_empty_after_N", {31'd0, empty}, 0);
    check("single_count_after_N", {27'd0, count}, 1);
    check("single_no_strobe_N1", {31'd0, uart_transmit}, 0);
    tick();
    check("single_empty_after_N1", {31'd0, empty}, 1);
    check("single_strobe_N2", {31'd0, uart_transmit}, 1);
    check("single_tx_byte", {24'd0, uart_tx_byte}, 32'hA5);
    tick();
    check("single_strobe_one_cycle", {31'd0, uart_transmit}, 0);
    check("single_busy_during_tx", {31'd0, busy}, 1);
    for (int i = 0; i < 30 && uart_busy; i++) tick();
    check("single_busy_after_fall", {31'd0, busy}, 0);
    wait_drain(50);

    // Fill to full with UART held busy, then overflow
    hold_busy = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) wr(8'(i), i < 16);
    wr_en = 1'b0;
    check("fill_full", {31'd0, full}, 1);
    check("fill_count", {27'd0, count}, 16);
    check("fill_overflow", {31'd0, overflow}, 1);
    wr(8'hEE, 1'b0);
    clr_ovf = 1'b1;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    check("ovf_beats_clear", {31'd0, overflow}, 1);
    check("ovf_count_held", {27'd0, count}, 16);
    tick();
    clr_ovf = 1'b0;
    check("clr_ovf", {31'd0, overflow}, 0);

    // Pop coincides with a write while full: write dropped
    gap_chk   = 1'b1;
    hold_busy = 1'b0;
    wr(8'h77, 1'b0);
    wr_en = 1'b0;
    check("full_pop_wr_count", {27'd0, count}, 15);
    check("full_pop_wr_overflow", {31'd0, overflow}, 1);
    check("full_pop_wr_full", {31'd0, full}, 0);
    wait_drain(400);
    gap_chk = 1'b0;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("clr_ovf_2", {31'd0, overflow}, 0);

    // Pop and accepted write on the same edge at count 5
    hold_busy = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) wr(8'hB0 + 8'(i), 1'b1);
    wr_en = 1'b0;
    check("five_count", {27'd0, count}, 5);
    hold_busy = 1'b0;
    wr(8'h55, 1'b1);
    wr_en = 1'b0;
    check("five_pop_wr_count", {27'd0, count}, 5);
    wait_drain(200);

    // 40 bytes in bursts: order and pointer wrap
    s0 = strobe_cnt;
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 8; i++) wr(8'(b * 8 + i), 1'b1);
      wr_en = 1'b0;
      repeat (90) tick();
    end
    wait_drain(400);
    check("burst_strobes", strobe_cnt - s0, 40);
    check("burst_count", {27'd0, count}, 0);

    // Reset in WAIT_DONE with 6 bytes queued; write in reset cycle ignored
    for (int i = 0; i < 7; i++) wr(8'hC0 + 8'(i), 1'b1);
    check("midrst_count_before", {27'd0, count}, 6);
    check("midrst_in_wait", {31'd0, uart_busy}, 1);
    rst     = 1'b1;
    wr_data = 8'h99;
    tick();
    exp_q.delete();
    rst   = 1'b0;
    wr_en = 1'b0;
    check("midrst_count", {27'd0, count}, 0);
    check("midrst_empty", {31'd0, empty}, 1);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_tx_byte", {24'd0, uart_tx_byte}, 0);
    s0 = strobe_cnt;
    repeat (20) tick();
    check("midrst_no_strobe", strobe_cnt - s0, 0);
    check("midrst_count_later", {27'd0, count}, 0);

    // UART busy before first write: launch waits for busy to drop
    hold_busy = 1'b1;
    tick();
    s0 = strobe_cnt;
    wr(8'h3C, 1'b1);
    wr_en = 1'b0;
    repeat (5) tick();
    check("prebusy_no_strobe", strobe_cnt - s0, 0);
    check("prebusy_count", {27'd0, count}, 1);
    hold_busy = 1'b0;
    tick();
    check("prebusy_strobe", {31'd0, uart_transmit}, 1);
    wait_drain(100);
    check("prebusy_strobes", strobe_cnt - s0, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
